// File: rtl/argmax_result_stage.sv
// argmax_result_stage: captures the final-layer vector and scans it one
// element per cycle for the index of the largest signed value.
module argmax_result_stage #(
    parameter int NUM_INPUTS = 10,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             soft_reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic [DATA_WIDTH-1:0]            max_value,
    output logic                             out_valid
);

    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CW = $clog2(NUM_INPUTS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] vec [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] cur_max;
    logic signed [DATA_WIDTH-1:0] elem;
    logic signed [DATA_WIDTH-1:0] in_elem0;
    logic [IW-1:0]                cur_idx;
    logic [IW-1:0]                sel;
    logic [CW-1:0]                cnt;

    assign in_ready = (state != SCAN);
    assign in_elem0 = in_data[DATA_WIDTH-1:0];
    // cnt reaches NUM_INPUTS on the final scan edge; keep the read in range
    assign sel      = (cnt < LAST) ? IW'(cnt) : '0;
    assign elem     = vec[sel];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_max   <= '0;
            cur_idx   <= '0;
            out_data  <= '0;
            max_value <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++)
                vec[i] <= '0;
        end else if (soft_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            out_data  <= '0;
            max_value <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_INPUTS; i++)
                            vec[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                        cur_max <= in_elem0;
                        cur_idx <= '0;
                        cnt     <= CW'(1);
                        if (NUM_INPUTS > 1) begin
                            state <= SCAN;
                        end else begin
                            state     <= DONE;
                            out_data  <= '0;
                            max_value <= in_elem0;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_data  <= OUT_WIDTH'(cur_idx);
                        max_value <= cur_max;
                        out_valid <= 1'b1;
                    end else begin
                        if (elem > cur_max) begin
                            cur_max <= elem;
                            cur_idx <= sel;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_result_stage.sv
// Bench for argmax_result_stage: vector table driven through a scoreboard
// plus hand sequences for soft_reset, async reset and back-to-back.
module tb_argmax_result_stage;

    localparam int N  = 10;
    localparam int DW = 16;

    logic            clk;
    logic            reset_n;
    logic            soft_reset;
    logic [N*DW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     out_data;
    logic [DW-1:0]   max_value;
    logic            out_valid;

    argmax_result_stage #(
        .NUM_INPUTS(N),
        .DATA_WIDTH(DW),
        .OUT_WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .soft_reset(soft_reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .max_value (max_value),
        .out_valid (out_valid)
    );

    typedef struct {
        logic [N*DW-1:0] data;
        int              idx;
        logic [DW-1:0]   mx;
    } vec_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] mx;
        int            due;
    } exp_t;

    vec_t tbl [8];
    exp_t sbq [$];
    int   pulses [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @cyc %0d",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic logic [N*DW-1:0] pk(input int v [N]);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            r[i*DW +: DW] = v[i][DW-1:0];
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid) begin
            pulses.push_back(cyc);
            chk("pulse_width", {63'd0, prev_ov}, 64'd0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse out_data=%0d expected none",
                         out_data);
            end else begin
                e = sbq.pop_front();
                chk("out_data", {32'd0, out_data}, 64'(e.idx));
                chk("max_value", {48'd0, max_value}, {48'd0, e.mx});
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input vec_t v, input bit keep);
        int n = 0;
        @(negedge clk);
        in_data  = v.data;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sbq.push_back('{v.idx, v.mx, cyc + N});
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{pk('{5, 12, -3, 40, 7, 0, 1, 2, 3, 4}), 3, 16'd40};
        tbl[1] = '{pk('{-8, -2, -100, -2, -50, -9, -7, -6, -5, -4}),
                   1, 16'hFFFE};
        tbl[2] = '{pk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32767}), 9, 16'h7FFF};
        tbl[3] = '{pk('{256, 256, 256, 256, 256, 256, 256, 256, 256, 256}),
                   0, 16'h0100};
        tbl[4] = '{pk('{1, 2, 3, 4, 5, 6, 99, 7, 8, 9}), 6, 16'd99};
        tbl[5] = '{pk('{-1, 0, 50, 3, 50, -7, 10, 49, 2, 1}), 2, 16'd50};
        tbl[6] = '{pk('{-32768, -32768, -32768, -32768, -32767,
                        -32768, -32768, -32768, -32768, -32768}),
                   4, 16'h8001};
        tbl[7] = '{pk('{32767, 0, 0, 0, 0, 32767, 0, 0, 0, 0}),
                   0, 16'h7FFF};

        reset_n    = 1'b0;
        soft_reset = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_max_value", {48'd0, max_value}, 64'd0);
        reset_n = 1'b1;

        // first vector: in_ready must stay low through the whole scan
        send(tbl[0], 1'b0);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("scan_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        chk("done_in_ready", {63'd0, in_ready}, 64'd1);
        wait_drain();

        for (int i = 1; i < 8; i++) begin
            if (i == 4 || i == 5) continue;
            send(tbl[i], 1'b0);
            wait_drain();
        end

        pulses.delete();
        send(tbl[4], 1'b1);
        send(tbl[5], 1'b1);
        in_valid = 1'b0;
        wait_drain();
        chk("b2b_pulses", 64'(pulses.size()), 64'd2);
        if (pulses.size() >= 2)
            chk("b2b_spacing", 64'(pulses[1] - pulses[0]), 64'd11);

        // soft_reset on the 4th scan edge aborts with no pulse
        @(negedge clk);
        in_data  = tbl[0].data;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        chk("sr_out_valid", {63'd0, out_valid}, 64'd0);
        chk("sr_out_data", {32'd0, out_data}, 64'd0);
        chk("sr_max_value", {48'd0, max_value}, 64'd0);
        chk("sr_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (15) @(negedge clk);

        // soft_reset beats in_valid on the same edge
        in_data    = tbl[2].data;
        in_valid   = 1'b1;
        soft_reset = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        soft_reset = 1'b0;
        chk("sr_valid_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (15) @(negedge clk);
        chk("sr_valid_out_data", {32'd0, out_data}, 64'd0);

        // asynchronous reset_n between edges mid-scan
        send(tbl[6], 1'b0);
        wait_drain();
        @(negedge clk);
        in_data  = tbl[0].data;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_data", {32'd0, out_data}, 64'd0);
        chk("arst_max_value", {48'd0, max_value}, 64'd0);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);

        // in_data changes during the scan must not affect the result
        send(tbl[1], 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++)
                in_data[j*DW +: DW] = 16'h7FFF;
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
